// File: rtl/calc_cursor_ctrl.sv
// calc_cursor_ctrl
// Keypad navigation controller for the calculator UI. It synchronises and
// debounces five raw push-buttons and keeps the cursor on the 4x3 button grid.
// On a select press it offers the key under the cursor to the calculator core.
//
// State table:
//   state | meaning
//   IDLE  | no key offer pending; a select press starts a new offer
//   OFFER | key_valid high, key_code frozen until key_valid & key_ready
//
// Ports:
//   clk_in     in   system clock
//   sys_rst    in   asynchronous active-high reset
//   btn_up     in   raw button, asynchronous to clk_in
//   btn_down   in   raw button, asynchronous to clk_in
//   btn_left   in   raw button, asynchronous to clk_in
//   btn_right  in   raw button, asynchronous to clk_in
//   btn_sel    in   raw button, asynchronous to clk_in
//   cursor_x   out  cursor column 0..2
//   cursor_y   out  cursor row 0..3
//   key_valid  out  key offer pending
//   key_code   out  offered key code, meaningful only while key_valid=1
//   key_ready  in   core accepts the offered key
//   key_drop   out  one-cycle pulse when a select press hits a pending offer
module calc_cursor_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk_in,
  input  logic       sys_rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  output logic [3:0] cursor_x,
  output logic [3:0] cursor_y,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
  output logic       key_drop
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  // Button bit positions: 0 sel, 1 up, 2 down, 3 left, 4 right.
  localparam int NB = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NB-1:0]    btn_raw;
  logic [NB-1:0]    sync_1;
  logic [NB-1:0]    sync_2;
  logic [NB-1:0]    stable;
  logic [NB-1:0]    stable_d;
  logic [CNT_W-1:0] cnt [NB];
  logic [NB-1:0]    press;

  logic sel_act, up_act, down_act, left_act, right_act;

  logic [1:0] x_q, y_q;
  state_t     state_q, state_d;
  logic       valid_q, valid_d;
  logic [3:0] code_q, code_d;
  logic       drop_q, drop_d;

  assign btn_raw = {btn_right, btn_left, btn_down, btn_up, btn_sel};

  always_ff @(posedge clk_in or posedge sys_rst) begin
    if (sys_rst) begin
      sync_1   <= '0;
      sync_2   <= '0;
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      sync_1   <= btn_raw;
      sync_2   <= sync_1;
      stable_d <= stable;
      for (int i = 0; i < NB; i++) begin
        if (sync_2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync_2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Rising edge of the debounced level; a held button yields one pulse.
  assign press = stable & ~stable_d;

  // Only the highest-priority press in a cycle acts.
  assign sel_act   = press[0];
  assign up_act    = press[1] & ~press[0];
  assign down_act  = press[2] & ~|press[1:0];
  assign left_act  = press[3] & ~|press[2:0];
  assign right_act = press[4] & ~|press[3:0];

  // y wraps naturally in 2 bits; x needs explicit wrap over 0..2.
  always_ff @(posedge clk_in or posedge sys_rst) begin
    if (sys_rst) begin
      x_q <= 2'd1;
      y_q <= 2'd1;
    end else begin
      if (up_act)    y_q <= y_q - 2'd1;
      if (down_act)  y_q <= y_q + 2'd1;
      if (left_act)  x_q <= (x_q == 2'd0) ? 2'd2 : x_q - 2'd1;
      if (right_act) x_q <= (x_q == 2'd2) ? 2'd0 : x_q + 2'd1;
    end
  end

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b11_00: code = 4'hA;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hB;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk_in or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      code_q  <= 4'h0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    code_d  = code_q;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_act) begin
          code_d  = key_map(y_q, x_q);
          valid_d = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        // A select arriving with the handshake is still dropped: no back-to-back offer.
        if (sel_act) drop_d = 1'b1;
        if (key_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cursor_x  = {2'b00, x_q};
  assign cursor_y  = {2'b00, y_q};
  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_drop  = drop_q;

endmodule
